fuzz_response_checker: RTL and testbench
========================================

// Module: fuzz_response_checker
// PURPOSE
//  Synthesizable response-side counterpart of the fuzz stimulus driver. Samples the DUT output bus y,
//  compares it against a golden expected-response stream (valid/ready) and folds every sample into a
//  MISR signature. Sits between the DUT (top) and the simulation/FPGA result reporter. Produces
//  pass/fail, mismatch count, first failing vector index and the final signature.
// PARAMETERS
//  Y_W      501           width of DUT output y and expected stream
//  CNT_W    16            width of vector counters/indices
//  LAT      1             cycles from start to first valid DUT sample (DUT register latency)
//  POLY     Y_W'h5        MISR feedback polynomial (applied when sig MSB is 1)
//  SEED     {Y_W{1'b0}}   MISR value loaded on start
// PORTS
//  clk             in   1      rising-edge clock
//  rst_n           in   1      synchronous active-low reset
//  start           in   1      one-cycle pulse; begins a run (ignored unless IDLE)
//  num_vecs        in   CNT_W  vectors to check; sampled on start
//  dut_y           in   Y_W    DUT output bus
//  exp_valid       in   1      expected word available
//  exp_y           in   Y_W    expected DUT output
//  exp_ready       out  1      checker consumes exp_y this cycle
//  busy            out  1      high in WAIT or RUN
//  done            out  1      one-cycle pulse when run completes
//  pass            out  1      1 when mismatch_cnt==0 at last completion
//  mismatch_cnt    out  CNT_W  mismatching vectors (saturating)
//  first_fail_idx  out  CNT_W  index of first mismatch; all-ones if none
//  signature       out  Y_W    MISR value
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): state=IDLE, exp_ready=0, busy=0, done=0, pass=0, mismatch_cnt=0,
//    first_fail_idx='1, signature=SEED, internal counters 0. Reset mid-run aborts; no done pulse.
//  - FSM IDLE -> WAIT -> RUN -> FIN -> IDLE.
//    IDLE: on start: latch num_vecs; clear mismatch_cnt, first_fail_idx='1, signature=SEED, pass=0.
//          If num_vecs==0 go FIN directly (done pulses, pass=1, signature=SEED). If LAT==0 go RUN else WAIT.
//    WAIT: count LAT-1 ... down; after exactly LAT cycles in WAIT go RUN.
//    RUN:  exp_ready=1. A "beat" = exp_valid && exp_ready. On a beat: compare dut_y vs exp_y
//          (full Y_W, bitwise, x-free); on mismatch increment mismatch_cnt (saturate at '1) and, if
//          first_fail_idx=='1, load vec_idx. MISR updates only on beats:
//          sig <= ({sig[Y_W-2:0],1'b0} ^ (sig[Y_W-1] ? POLY : 0)) ^ dut_y.
//          vec_idx increments per beat; beat with vec_idx==num_vecs-1 -> FIN. No beat = stall, no update.
//    FIN:  exp_ready=0; done=1 for this one cycle; pass=(mismatch_cnt==0); next IDLE.
//  - Outputs registered; results hold in IDLE until next start. start while busy is ignored.
//  - start and done in the same cycle (FIN): start ignored (FSM not IDLE).
//  - vec_idx counts 0..num_vecs-1; no wrap since num_vecs<=2^CNT_W-1.
// STRUCTURE
//  - Package fuzz_chk_pkg: state enum {IDLE,WAIT,RUN,FIN}, CNT_W default, MISR step function.
//  - Sub-module fuzz_misr (Y_W, POLY, SEED): load, enable, data_in -> sig; instantiated once.
//  - Top holds FSM, latency counter, vector counter, comparator, result registers.
// TESTING
//  1 Reset: rst_n=0 2 cycles -> all outputs at reset values, first_fail_idx=16'hFFFF.
//  2 Clean run: num_vecs=21, exp_y==dut_y all beats, exp_valid=1 -> done at 1+LAT+21 cycles after
//    start, pass=1, mismatch_cnt=0, signature equals reference MISR model.
//  3 Errors: num_vecs=8, flip bit 0 of exp_y on vectors 3 and 6 -> mismatch_cnt=2, first_fail_idx=3, pass=0.
//  4 Stall: exp_valid low on 5 random RUN cycles, num_vecs=4 -> done delayed 5 cycles, signature
//    identical to no-stall run.
//  5 Edges: num_vecs=0 -> done next cycle, pass=1, signature=SEED; start while busy -> no effect.
//  6 Reset mid-RUN after 3 beats -> IDLE, no done, counters cleared; fresh start runs normally.

Source files
------------

// File: rtl/fuzz_chk_pkg.sv
// Shared types and helpers for the fuzz response checker.
// State encoding, default widths and the MISR step function.
package fuzz_chk_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int Y_W_DEF = 501;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RUN,
    FIN
  } state_e;

  function automatic logic [Y_W_DEF-1:0] misr_step(
    input logic [Y_W_DEF-1:0] sig,
    input logic [Y_W_DEF-1:0] poly,
    input logic [Y_W_DEF-1:0] din
  );
    return {sig[Y_W_DEF-2:0], 1'b0}
         ^ (sig[Y_W_DEF-1] ? poly : '0)
         ^ din;
  endfunction

endpackage

// File: rtl/fuzz_misr.sv
// Multiple-input signature register.
// Loads SEED on load, folds din in on en.
module fuzz_misr
  import fuzz_chk_pkg::*;
#(
  parameter int Y_W = Y_W_DEF,
  parameter logic [Y_W-1:0] POLY = Y_W'(5),
  parameter logic [Y_W-1:0] SEED = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           en,
  input  logic [Y_W-1:0] din,
  output logic [Y_W-1:0] sig
);

  logic [Y_W-1:0] sig_q, sig_d, step;

  if (Y_W == Y_W_DEF) begin : g_pkg
    assign step = misr_step(sig_q, POLY, din);
  end else begin : g_gen
    assign step = {sig_q[Y_W-2:0], 1'b0}
                ^ (sig_q[Y_W-1] ? POLY : '0)
                ^ din;
  end

  // Next signature: reload wins over a fold.
  always_comb begin
    sig_d = sig_q;
    if (load) sig_d = SEED;
    else if (en) sig_d = step;
  end

  // Signature register.
  always_ff @(posedge clk) begin
    if (!rst_n) sig_q <= SEED;
    else sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/fuzz_response_checker.sv
// Compares DUT output against a golden stream and signs it.
// Reports pass, mismatch count, first failing index, signature.
module fuzz_response_checker
  import fuzz_chk_pkg::*;
#(
  parameter int Y_W = Y_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LAT = 1,
  parameter logic [Y_W-1:0] POLY = Y_W'(5),
  parameter logic [Y_W-1:0] SEED = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vecs,
  input  logic [Y_W-1:0]   dut_y,
  input  logic             exp_valid,
  input  logic [Y_W-1:0]   exp_y,
  output logic             exp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [Y_W-1:0]   signature
);

  localparam logic [CNT_W-1:0] ALL1 = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAT_M1 =
    (LAT > 0) ? CNT_W'(LAT - 1) : '0;

  state_e state_q, state_d;

  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] mis_q, mis_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic             pass_q, pass_d;

  logic go, beat, last, miss;

  assign go   = (state_q == IDLE) && start;
  assign beat = (state_q == RUN) && exp_valid;
  assign last = (vec_q == num_q - ONE);
  assign miss = (dut_y != exp_y);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Next state: empty runs skip straight to FIN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_vecs == '0) state_d = FIN;
          else if (LAT == 0) state_d = RUN;
          else state_d = WAIT;
        end
      end
      WAIT: if (lat_q == '0) state_d = RUN;
      RUN: if (beat && last) state_d = FIN;
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    exp_ready = (state_q == RUN);
    busy = (state_q == WAIT) || (state_q == RUN);
    done = (state_q == FIN);
  end

  // Counters and results; pass settles as FIN is entered.
  always_comb begin
    lat_d  = lat_q;
    vec_d  = vec_q;
    num_d  = num_q;
    mis_d  = mis_q;
    ffi_d  = ffi_q;
    pass_d = pass_q;
    if (go) begin
      num_d  = num_vecs;
      lat_d  = LAT_M1;
      vec_d  = '0;
      mis_d  = '0;
      ffi_d  = ALL1;
      pass_d = (num_vecs == '0);
    end
    if (state_q == WAIT && lat_q != '0) begin
      lat_d = lat_q - ONE;
    end
    if (beat) begin
      vec_d = vec_q + ONE;
      if (miss) begin
        if (mis_q != ALL1) mis_d = mis_q + ONE;
        if (ffi_q == ALL1) ffi_d = vec_q;
      end
      if (last) pass_d = (mis_d == '0);
    end
  end

  // Counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_q  <= '0;
      vec_q  <= '0;
      num_q  <= '0;
      mis_q  <= '0;
      ffi_q  <= ALL1;
      pass_q <= 1'b0;
    end else begin
      lat_q  <= lat_d;
      vec_q  <= vec_d;
      num_q  <= num_d;
      mis_q  <= mis_d;
      ffi_q  <= ffi_d;
      pass_q <= pass_d;
    end
  end

  assign pass = pass_q;
  assign mismatch_cnt = mis_q;
  assign first_fail_idx = ffi_q;

  fuzz_misr #(
    .Y_W (Y_W),
    .POLY(POLY),
    .SEED(SEED)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (go),
    .en   (beat),
    .din  (dut_y),
    .sig  (signature)
  );

endmodule

// File: tb/tb_fuzz_response_checker.sv
// Directed bench for fuzz_response_checker.
// Expected run results are queued at launch and popped at done.
module tb_fuzz_response_checker;

  localparam int Y_W = 501;
  localparam int CNT_W = 16;
  localparam int LAT = 1;
  localparam logic [Y_W-1:0] POLY = 501'h5;

  typedef struct {
    int cyc;
    int mis;
    int ffi;
    bit pass;
    logic [Y_W-1:0] sig;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vecs = '0;
  logic [Y_W-1:0]   dut_y = '0;
  logic             exp_valid = 1'b0;
  logic [Y_W-1:0]   exp_y = '0;
  logic             exp_ready;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] first_fail_idx;
  logic [Y_W-1:0]   signature;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  logic [Y_W-1:0] dv[64];
  logic [Y_W-1:0] ev[64];

  fuzz_response_checker #(
    .Y_W(Y_W),
    .CNT_W(CNT_W),
    .LAT(LAT),
    .POLY(POLY),
    .SEED('0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .num_vecs(num_vecs),
    .dut_y(dut_y),
    .exp_valid(exp_valid),
    .exp_y(exp_y),
    .exp_ready(exp_ready),
    .busy(busy),
    .done(done),
    .pass(pass),
    .mismatch_cnt(mismatch_cnt),
    .first_fail_idx(first_fail_idx),
    .signature(signature)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [Y_W-1:0] obs,
                     input logic [Y_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic gen(input int n, input logic [63:0] flips);
    logic [Y_W-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = '0;
      repeat (16) v = {v[Y_W-33:0], 32'($urandom)};
      dv[i] = v;
      ev[i] = v ^ Y_W'(flips[i]);
    end
  endtask

  task automatic run(input int n, input int nstall, input int poke);
    exp_t e, g;
    logic [Y_W-1:0] m;
    int beat, cyc, stalls;
    bit seen, stall;
    m = '0;
    e.mis = 0;
    e.ffi = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      m = (m << 1) ^ (m[Y_W-1] ? POLY : '0) ^ dv[i];
      if (dv[i] !== ev[i]) begin
        if (e.mis == 0) e.ffi = i;
        e.mis++;
      end
    end
    e.pass = (e.mis == 0);
    e.sig = m;
    e.cyc = (n == 0) ? 1 : 1 + LAT + n + nstall;
    @(negedge clk);
    sb.push_back(e);
    start = 1'b1;
    num_vecs = CNT_W'(n);
    exp_valid = 1'b1;
    cyc = 0;
    beat = 0;
    stalls = nstall;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke);
      if (cyc == poke) num_vecs = CNT_W'(1);
      if (done) begin
        seen = 1'b1;
      end else if (exp_ready && beat < n) begin
        stall = (stalls > 0) &&
                ($urandom_range(0, 1) == 1 || beat == n - 1);
        if (stall) stalls--;
        exp_valid = !stall;
        dut_y = dv[beat];
        exp_y = ev[beat];
        if (!stall) beat++;
      end else begin
        exp_valid = 1'b0;
      end
    end
    start = 1'b0;
    g = sb.pop_front();
    chk("done_seen", Y_W'(seen), Y_W'(1));
    chk("latency", Y_W'(cyc), Y_W'(g.cyc));
    chk("mismatch_cnt", Y_W'(mismatch_cnt), Y_W'(g.mis));
    chk("first_fail_idx", Y_W'(first_fail_idx), Y_W'(g.ffi));
    chk("pass", Y_W'(pass), Y_W'(g.pass));
    chk("signature", signature, g.sig);
    chk("busy_at_done", Y_W'(busy), Y_W'(0));
    @(negedge clk);
    chk("done_one_cycle", Y_W'(done), Y_W'(0));
    chk("sig_hold", signature, g.sig);
    chk("pass_hold", Y_W'(pass), Y_W'(g.pass));
  endtask

  initial begin
    int beat;
    bit anyd;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_exp_ready", Y_W'(exp_ready), Y_W'(0));
    chk("rst_busy", Y_W'(busy), Y_W'(0));
    chk("rst_done", Y_W'(done), Y_W'(0));
    chk("rst_pass", Y_W'(pass), Y_W'(0));
    chk("rst_mis", Y_W'(mismatch_cnt), Y_W'(0));
    chk("rst_ffi", Y_W'(first_fail_idx), Y_W'(16'hFFFF));
    chk("rst_sig", signature, '0);
    rst_n = 1'b1;

    gen(21, 64'h0);
    run(21, 0, 0);

    gen(8, 64'h48);
    run(8, 0, 0);

    gen(4, 64'h0);
    run(4, 0, 0);
    run(4, 5, 0);

    run(0, 0, 0);

    gen(21, 64'h20);
    run(21, 0, 3);

    gen(10, 64'h2);
    @(negedge clk);
    start = 1'b1;
    num_vecs = CNT_W'(10);
    exp_valid = 1'b1;
    beat = 0;
    anyd = 1'b0;
    for (int c = 0; c < 50 && beat < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) anyd = 1'b1;
      if (exp_ready) begin
        dut_y = dv[beat];
        exp_y = ev[beat];
        beat++;
      end
    end
    @(negedge clk);
    if (done) anyd = 1'b1;
    chk("abort_pre_mis", Y_W'(mismatch_cnt), Y_W'(1));
    chk("abort_pre_ffi", Y_W'(first_fail_idx), Y_W'(1));
    chk("abort_pre_busy", Y_W'(busy), Y_W'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    if (done) anyd = 1'b1;
    chk("abort_no_done", Y_W'(anyd), Y_W'(0));
    chk("abort_busy", Y_W'(busy), Y_W'(0));
    chk("abort_ready", Y_W'(exp_ready), Y_W'(0));
    chk("abort_mis", Y_W'(mismatch_cnt), Y_W'(0));
    chk("abort_ffi", Y_W'(first_fail_idx), Y_W'(16'hFFFF));
    chk("abort_sig", signature, '0);
    @(negedge clk);
    chk("abort_idle_done", Y_W'(done), Y_W'(0));

    gen(5, 64'h10);
    run(5, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
